// File: rtl/cve2_sleep_ctrl_pkg.sv
// Shared types for the sleep/wake controller: FSM state encoding and stats width.
package cve2_sleep_ctrl_pkg;

  typedef enum logic [1:0] {
    ACTIVE    = 2'd0,
    IDLE_HOLD = 2'd1,
    SLEEP     = 2'd2
  } sleep_state_e;

  localparam int unsigned SLEEP_STATS_W = 32;

  // Idle-hold counter width; never below one bit so the zero-hold build still elaborates.
  function automatic int unsigned hold_cnt_w(input int unsigned hold_cycles);
    int unsigned w;
    w = 0;
    while ((1 << w) < (hold_cycles + 1)) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cve2_clock_gate.sv
// Latch-based clock gate: enable captured while clk_i is low, scan enable forces the clock on.
module cve2_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_latch;

  always_latch begin
    if (!clk_i) begin
      en_latch <= en_i | scan_cg_en_i;
    end
  end

  assign clk_o = en_latch & clk_i;

endmodule

// File: rtl/cve2_wake_sync.sv
// Two-flop vector synchroniser for asynchronous wake levels, async active-low reset.
module cve2_wake_sync #(
  parameter int unsigned Width = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] sync_p0;
  logic [Width-1:0] sync_p1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d_i;
      sync_p1 <= sync_p0;
    end
  end

  assign q_o = sync_p1;

endmodule

// File: rtl/cve2_sleep_ctrl.sv
// Sleep/wake controller with idle hysteresis, maskable wake sources and wake-cause capture.
// Optional gated-cycle statistics counter enabled by defining CVE2_SLEEP_STATS_EN.
module cve2_sleep_ctrl
  import cve2_sleep_ctrl_pkg::*;
#(
  parameter int unsigned NumWakeSrc     = 4,
  parameter int unsigned IdleHoldCycles = 2,
  parameter bit          WakeSync       = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     test_en_i,
  input  logic                     core_busy_i,
  input  logic [NumWakeSrc-1:0]    wake_i,
  input  logic [NumWakeSrc-1:0]    wake_mask_i,
  input  logic                     irq_nm_i,
  input  logic                     debug_req_i,
  output logic                     clk_o,
  output logic                     clk_en_o,
  output logic                     core_sleep_o,
  output logic [1:0]               sleep_state_o,
  output logic [NumWakeSrc+1:0]    wake_cause_o,
  output logic [SLEEP_STATS_W-1:0] sleep_cycles_o
);

  localparam int unsigned CntW = hold_cnt_w(IdleHoldCycles);
  localparam logic [CntW-1:0] HoldLoad =
    CntW'((IdleHoldCycles > 0) ? IdleHoldCycles - 1 : 0);

  logic [NumWakeSrc-1:0] wake_s;
  logic [NumWakeSrc-1:0] wake_masked;
  logic                  wake_any;

  sleep_state_e          state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [NumWakeSrc+1:0] cause_q, cause_d;

  // nmi and debug bypass the synchroniser so they never pay its latency
  if (WakeSync) begin : g_sync
    cve2_wake_sync #(
      .Width (NumWakeSrc)
    ) u_wake_sync (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .d_i    (wake_i),
      .q_o    (wake_s)
    );
  end else begin : g_nosync
    assign wake_s = wake_i;
  end

  assign wake_masked = wake_s & wake_mask_i;
  assign wake_any    = (|wake_masked) | irq_nm_i | debug_req_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACTIVE;
      cnt_q   <= '0;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;
    unique case (state_q)
      ACTIVE: begin
        if (!core_busy_i && !wake_any) begin
          if (IdleHoldCycles == 0) begin
            state_d = SLEEP;
          end else begin
            state_d = IDLE_HOLD;
            cnt_d   = HoldLoad;
          end
        end
      end
      IDLE_HOLD: begin
        // Activity beats a counter that expires in the same cycle.
        if (core_busy_i || wake_any) begin
          state_d = ACTIVE;
        end else if (cnt_q == '0) begin
          state_d = SLEEP;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      SLEEP: begin
        if (wake_any || core_busy_i) begin
          state_d = ACTIVE;
          cause_d = {debug_req_i, irq_nm_i, wake_masked};
        end
      end
      default: state_d = ACTIVE;
    endcase
  end

  // Clock resumes combinationally with the wake, ahead of the state change.
  always_comb begin
    clk_en_o = (state_q != SLEEP) | wake_any;
  end

  assign core_sleep_o  = ~clk_en_o;
  assign sleep_state_o = state_q;
  assign wake_cause_o  = cause_q;

  cve2_clock_gate u_clock_gate (
    .clk_i        (clk_i),
    .en_i         (clk_en_o),
    .scan_cg_en_i (test_en_i),
    .clk_o        (clk_o)
  );

`ifdef CVE2_SLEEP_STATS_EN
  logic [SLEEP_STATS_W-1:0] sleep_cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sleep_cycles_q <= '0;
    end else if (!clk_en_o && (sleep_cycles_q != '1)) begin
      sleep_cycles_q <= sleep_cycles_q + SLEEP_STATS_W'(1);
    end
  end

  assign sleep_cycles_o = sleep_cycles_q;
`else
  assign sleep_cycles_o = '0;
`endif

endmodule
